// File: rtl/timer_pkg.sv
// Shared types and constants for the loadable down-timer.
package timer_pkg;

    localparam int unsigned TIMER_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/down_counter_core.sv
// Count register owned by the timer: clear, parallel load and decrement, in that priority.
module down_counter_core
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             dec,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_data;
        end else if (dec) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Q = count_q;

endmodule

// File: rtl/down_timer4bit.sv
// Loadable down-timer with one-shot / auto-reload modes and a registered terminal-count pulse.
module down_timer4bit
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             auto_q, auto_d;
    logic             tc_q, tc_d;

    logic             cnt_clr;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_data;
    logic             cnt_dec;

    always_comb begin
        state_d       = state_q;
        reload_d      = reload_q;
        auto_d        = auto_q;
        tc_d          = 1'b0;
        cnt_clr       = 1'b0;
        cnt_load      = 1'b0;
        cnt_load_data = load_val;
        cnt_dec       = 1'b0;

        if (stop) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else if (start) begin
            cnt_load = 1'b1;
            reload_d = load_val;
            auto_d   = auto_reload;
            if (load_val != '0) begin
                state_d = RUN;
            end else begin
                // Zero load finishes at once, even in auto-reload mode.
                state_d = DONE;
                tc_d    = 1'b1;
            end
        end else if (state_q == RUN && en) begin
            if (Q == '0) begin
                cnt_load      = 1'b1;
                cnt_load_data = reload_q;
            end else begin
                cnt_dec = 1'b1;
                if (Q == WIDTH'(1)) begin
                    tc_d    = 1'b1;
                    state_d = auto_q ? RUN : DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            reload_q <= '0;
            auto_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            auto_q   <= auto_d;
            tc_q     <= tc_d;
        end
    end

    down_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .load      (cnt_load),
        .load_data (cnt_load_data),
        .dec       (cnt_dec),
        .Q         (Q)
    );

    assign tc   = tc_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: doc/down_timer4bit.md
# down_timer4bit

Loadable 4-bit count-down timer with one-shot and auto-reload modes, a registered terminal-count pulse and a small control FSM. It complements the ALU's free-running up-counter and provides programmable delays and periodic ticks to ALU sequencing logic. Counting advances only on cycles where `en` is high, so an external enable or prescaler sets the tick rate.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  single-cycle request. Loads `load_val`, captures `auto_reload` and enters RUN.
- `stop`  in  1  abort. Returns to IDLE and clears `Q`.
- `en`  in  1  count enable. Qualifies every decrement and reload.
- `auto_reload`  in  1  mode select, sampled only on accepted `start`. 1 = periodic, 0 = one-shot.
- `load_val`  in  WIDTH  initial and reload value.
- `Q`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal count. High for exactly one cycle when `Q` becomes 0.
- `busy`  out  1  high while the FSM is in RUN.
- `done`  out  1  high while the FSM is in DONE (one-shot finished).

## Operation
- States: IDLE, RUN, DONE.
- Internal registers: `reload_r` (WIDTH bits) and `auto_r` (1 bit), both captured on an accepted `start`.
- Input priority, highest first: `rst` > `stop` > `start` > `en`.
- Reset state: FSM in IDLE; `Q`, `reload_r`, `auto_r`, `tc`, `busy` and `done` all 0.
- `stop` in any state:
  - next state IDLE, `Q` <= 0, `tc` <= 0.
- `start` in any state, including mid-RUN (restart):
  - `Q` <= `load_val`, `reload_r` <= `load_val`, `auto_r` <= `auto_reload`.
  - If `load_val` != 0: next state RUN.
  - If `load_val` == 0: next state DONE and `tc` <= 1. `auto_reload` is ignored in this case; there is no zero-period oscillation.
- RUN with `en` = 1:
  - `Q` > 1: `Q` <= `Q` - 1.
  - `Q` == 1: `Q` <= 0 and `tc` <= 1. Next state is RUN if `auto_r` = 1, otherwise DONE.
  - `Q` == 0 (only reachable with `auto_r` = 1): `Q` <= `reload_r`, stay in RUN.
- RUN with `en` = 0: `Q` holds, state holds, `tc` <= 0.
- IDLE and DONE: `Q` holds (0 in DONE). Only `start`, `stop` or `rst` leave these states.
- `tc` defaults to 0 on every cycle not listed above. It is never asserted for two consecutive cycles.
- Arithmetic: the decrement is WIDTH-bit and never underflows, because 0 is always handled by reload or by leaving RUN.
- Outputs are decoded from the state register: `busy` = (state == RUN), `done` = (state == DONE). Neither has combinational input-to-output paths.

## Timing
- `start` sampled at edge k, `load_val` = N > 0: `Q` = N and `busy` = 1 from cycle k+1.
- One-shot with `en` held high:
  - `Q` = 0, `tc` = 1, `done` = 1 and `busy` = 0 all in cycle k+1+N.
  - `tc` = 0 from k+2+N.
- Auto-reload with `en` held high:
  - `Q` = 0 with `tc` = 1 in cycle k+1+N.
  - `Q` = N again at k+2+N.
  - Period is N+1 enabled cycles.
- `start` with `load_val` = 0: `Q` = 0, `tc` = 1 and `done` = 1 at k+1.
- Gaps in `en` stretch the timeline one-for-one; the count of enabled cycles is unchanged.
- `rst` or `stop` at edge j: all outputs at their IDLE values from cycle j+1. Any `tc` that would have fired at j+1 is suppressed.
- `start` and `stop` high together: `stop` wins.

## Structure
- Package `timer_pkg` holds:
  - the `timer_state_t` enum: IDLE, RUN, DONE.
  - the `TIMER_WIDTH_DEFAULT` = 4 constant.
- Optional sub-module `down_counter_core`:
  - parameterised register with `load`, `load_data`, `dec` and `clr` inputs, and a `Q` output.
  - owns `Q`; the FSM in `down_timer4bit` drives its controls.

## Test plan
- Reset: assert `rst` for 2 cycles mid-count → `Q` = 0, `tc`/`busy`/`done` = 0, state IDLE, no `tc` glitch afterwards.
- One-shot: `start` with `load_val` = 5, `auto_reload` = 0, `en` = 1 → `Q` = 5,4,3,2,1,0 on consecutive cycles; single `tc` pulse when `Q` = 0, 6 cycles after `start`; `done` = 1, `busy` = 0 held until the next `start`.
- Auto-reload: `load_val` = 3, `auto_reload` = 1 → `Q` = 3,2,1,0,3,2,1,0,…; `tc` exactly every 4 cycles; `busy` stays 1 and `done` stays 0.
- Enable gating: `load_val` = 2, `en` toggling 1,0,1,0 → `Q` holds during `en` = 0 cycles; `tc` occurs after 2 enabled cycles, 4 clock cycles after load.
- Zero load: `start` with `load_val` = 0 and `auto_reload` = 1 → next cycle `Q` = 0, `tc` = 1 for one cycle, `done` = 1, no further `tc` pulses.
- Mid-run control:
  - `start` with 9 while `Q` = 4 → `Q` = 9 next cycle, no `tc`.
  - `stop` together with `start` → IDLE, `Q` = 0.
  - `stop` on the cycle `Q` = 1 → no `tc` pulse.
